// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE -> ISSUE -> DELIVER -> IDLE)
//   ID_MAX      : widest destination-ID field the helper can return
//   W_MAX       : widest word the helper can accept
//   BCAST_ID    : all-ones destination ID (broadcast when BUS_BCAST_EN is defined)
//   get_dest()  : extracts the destination-ID field from the top of a word
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DELIVER = 2'd2
  } arb_state_e;

  localparam int ID_MAX = 16;
  localparam int W_MAX  = 64;

  // Callers compare only the low ID_W bits of this constant.
  localparam logic [ID_MAX-1:0] BCAST_ID = {ID_MAX{1'b1}};

  // Returns word[width-1 -: id_w], zero-extended to ID_MAX bits.
  function automatic logic [ID_MAX-1:0] get_dest(input logic [W_MAX-1:0] word,
                                                 input int width,
                                                 input int id_w);
    logic [ID_MAX-1:0] field;
    field = ID_MAX'(word >> (width - id_w));
    return field & ~({ID_MAX{1'b1}} << id_w);
  endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational round-robin priority selector.
//   req     : request vector, one bit per device
//   ptr     : index of the last device granted; search starts at ptr+1
//   gnt_idx : index of the winning device (meaningful when gnt_vld=1)
//   gnt_vld : at least one request is set
// The request vector is rotated so that device ptr+1 sits at bit 0,
// the lowest set bit is found, and the result is rotated back.
module rr_prio_sel #(
  parameter int DRVRS = 4
) (
  input  logic [DRVRS-1:0]         req,
  input  logic [$clog2(DRVRS)-1:0] ptr,
  output logic [$clog2(DRVRS)-1:0] gnt_idx,
  output logic                     gnt_vld
);

  localparam int PW = $clog2(DRVRS);
  localparam logic [PW-1:0] LAST = PW'(DRVRS - 1);
  localparam logic [PW:0]   WRAP = (PW + 1)'(DRVRS);

  logic [PW-1:0]    start_s;
  logic [PW-1:0]    idx_s;
  logic [DRVRS-1:0] rot_s;
  logic [PW:0]      sum_s;

  // Rotate, priority-encode the lowest set bit, rotate back (mod DRVRS).
  always_comb begin
    start_s = (ptr == LAST) ? {PW{1'b0}} : ptr + PW'(1'b1);
    rot_s   = DRVRS'({req, req} >> start_s);
    idx_s   = {PW{1'b0}};
    // Descending scan so the lowest set bit is the last one written.
    for (int i = DRVRS - 1; i >= 0; i--) begin
      idx_s = rot_s[i] ? PW'(i) : idx_s;
    end
    sum_s   = {1'b0, idx_s} + {1'b0, start_s};
    gnt_idx = (sum_s >= WRAP) ? PW'(sum_s - WRAP) : sum_s[PW-1:0];
    gnt_vld = |req;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one emulated bus among DRVRS device FIFOs.
// One word moves per transfer: grant a pending source (IDLE), pop it and
// capture its head word (ISSUE), then push the word into the destination
// FIFO named in its top ID_W bits once that FIFO has room (DELIVER).
//
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   pndng_i    : source FIFO i non-empty
//   dato_i     : flattened source head words, slice i = [i*WIDTH +: WIDTH]
//   pop_o      : one-cycle pop strobe to the granted source
//   full_i     : destination FIFO i full
//   push_o     : one-cycle push strobe to the destination(s)
//   dato_o     : word on the bus, valid while any push_o bit is high
//   gnt_id_o   : index of the current grant holder
//   busy_o     : high whenever the FSM is not in IDLE
//   err_o      : one-cycle pulse when a word is dropped
//
// Configuration macro BUS_BCAST_EN: when defined, the all-ones destination
// ID is a broadcast to every device except the source; when undefined it is
// treated as an invalid destination and dropped with an err_o pulse.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int DRVRS = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DRVRS-1:0]         pndng_i,
  input  logic [DRVRS*WIDTH-1:0]   dato_i,
  output logic [DRVRS-1:0]         pop_o,
  input  logic [DRVRS-1:0]         full_i,
  output logic [DRVRS-1:0]         push_o,
  output logic [WIDTH-1:0]         dato_o,
  output logic [$clog2(DRVRS)-1:0] gnt_id_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int PW = $clog2(DRVRS);
  localparam logic [DRVRS-1:0]  ONE_HOT0 = {{(DRVRS - 1){1'b0}}, 1'b1};
  localparam logic [ID_MAX-1:0] DRVRS_ID = ID_MAX'(DRVRS);

  arb_state_e        state_r;
  arb_state_e        state_s;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     ptr_s;
  logic [PW-1:0]     gnt_s;
  logic [WIDTH-1:0]  word_s;
  logic [WIDTH-1:0]  src_word_s;
  logic [DRVRS-1:0]  pop_s;
  logic [DRVRS-1:0]  push_s;
  logic              err_s;
  logic [PW-1:0]     sel_idx_s;
  logic              sel_vld_s;
  logic [ID_MAX-1:0] dest_s;
  logic [DRVRS-1:0]  dest_oh_s;
  logic [DRVRS-1:0]  src_oh_s;
  logic              dest_ok_s;
  logic              bcast_s;

  rr_prio_sel #(
    .DRVRS (DRVRS)
  ) u_sel (
    .req     (pndng_i),
    .ptr     (ptr_r),
    .gnt_idx (sel_idx_s),
    .gnt_vld (sel_vld_s)
  );

  // Head word of the current grant holder.
  always_comb begin
    src_word_s = {WIDTH{1'b0}};
    for (int i = 0; i < DRVRS; i++) begin
      src_word_s = (gnt_id_o == PW'(i)) ? dato_i[i*WIDTH +: WIDTH] : src_word_s;
    end
  end

  // The captured word lives in dato_o, so the destination is decoded from it.
  always_comb begin
    dest_s    = get_dest(W_MAX'(dato_o), WIDTH, ID_W);
    src_oh_s  = ONE_HOT0 << gnt_id_o;
    dest_oh_s = ONE_HOT0 << dest_s[PW-1:0];
    dest_ok_s = (dest_s < DRVRS_ID) && (dest_s != ID_MAX'(gnt_id_o));
  end

`ifdef BUS_BCAST_EN
  assign bcast_s = (dest_s[ID_W-1:0] == BCAST_ID[ID_W-1:0]);
`else
  assign bcast_s = 1'b0;
`endif

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gnt_s   = gnt_id_o;
    word_s  = dato_o;
    pop_s   = {DRVRS{1'b0}};
    push_s  = {DRVRS{1'b0}};
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_vld_s) begin
          gnt_s   = sel_idx_s;
          ptr_s   = sel_idx_s;
          // Registered, so the pop strobe is visible during ISSUE.
          pop_s   = ONE_HOT0 << sel_idx_s;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // The head word is still valid here; the FIFO pops on this edge.
        word_s  = src_word_s;
        state_s = DELIVER;
      end
      DELIVER: begin
        if (bcast_s) begin
          // The source's own full flag is irrelevant to a broadcast.
          if ((full_i & ~src_oh_s) == {DRVRS{1'b0}}) begin
            push_s  = ~src_oh_s;
            state_s = IDLE;
          end else begin
            state_s = DELIVER;
          end
        end else if (!dest_ok_s) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else if ((full_i & dest_oh_s) == {DRVRS{1'b0}}) begin
          push_s  = dest_oh_s;
          state_s = IDLE;
        end else begin
          state_s = DELIVER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= PW'(DRVRS - 1);
      gnt_id_o <= {PW{1'b0}};
      dato_o   <= {WIDTH{1'b0}};
      pop_o    <= {DRVRS{1'b0}};
      push_o   <= {DRVRS{1'b0}};
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      gnt_id_o <= gnt_s;
      dato_o   <= word_s;
      pop_o    <= pop_s;
      push_o   <= push_s;
      err_o    <= err_s;
      busy_o   <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (DRVRS=4, WIDTH=16, ID_W=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  pndng_i = 4'b0000;
  logic [63:0] dato_i = 64'h0;
  logic [3:0]  pop_o;
  logic [3:0]  full_i = 4'b0000;
  logic [3:0]  push_o;
  logic [15:0] dato_o;
  logic [1:0]  gnt_id_o;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  bus_rr_arbiter #(
    .DRVRS (4),
    .WIDTH (16),
    .ID_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pndng_i  (pndng_i),
    .dato_i   (dato_i),
    .pop_o    (pop_o),
    .full_i   (full_i),
    .push_o   (push_o),
    .dato_o   (dato_o),
    .gnt_id_o (gnt_id_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    dato_i[i*16 +: 16] = w;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"},  32'(pop_o),    32'h0);
    check({tag, "_push"}, 32'(push_o),   32'h0);
    check({tag, "_dato"}, 32'(dato_o),   32'h0);
    check({tag, "_gnt"},  32'(gnt_id_o), 32'h0);
    check({tag, "_busy"}, 32'(busy_o),   32'h0);
    check({tag, "_err"},  32'(err_o),    32'h0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  exp_push;

    // 1) reset state, then one word from device 0 to device 2
    tick();
    tick();
    check_all_zero("rst");
    rst = 1'b0;
    pndng_i = 4'b0001;
    set_word(0, 16'h0206);
    tick();                                   // grant edge
    check("t1_pop",  32'(pop_o),    32'h1);
    check("t1_gnt",  32'(gnt_id_o), 32'h0);
    check("t1_busy", 32'(busy_o),   32'h1);
    pndng_i = 4'b0000;
    tick();                                   // ISSUE -> DELIVER
    check("t1_pop_off", 32'(pop_o),  32'h0);
    check("t1_nopush",  32'(push_o), 32'h0);
    tick();                                   // push edge
    check("t1_push",  32'(push_o), 32'h4);
    check("t1_dato",  32'(dato_o), 32'h0206);
    check("t1_idle",  32'(busy_o), 32'h0);
    check("t1_err",   32'(err_o),  32'h0);
    tick();
    check("t1_push_off", 32'(push_o), 32'h0);

    // 2) all pending, each word to (i+1)%4; grant order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_word(i, {8'((i + 1) % 4), 8'(8'h10 + i)});
    end
    pndng_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w        = {8'(((k % 4) + 1) % 4), 8'(8'h10 + (k % 4))};
      exp_push = 4'b0001 << (((k % 4) + 1) % 4);
      tick();
      check($sformatf("t2_gnt%0d", k), 32'(gnt_id_o), 32'(k % 4));
      check($sformatf("t2_pop%0d", k), 32'(pop_o),    32'(4'b0001 << (k % 4)));
      tick();
      tick();
      if (k == 4) pndng_i = 4'b0000;
      check($sformatf("t2_push%0d", k), 32'(push_o), 32'(exp_push));
      check($sformatf("t2_dato%0d", k), 32'(dato_o), 32'(w));
      check($sformatf("t2_err%0d", k),  32'(err_o),  32'h0);
    end

    // 3) destination 1 full for 5 cycles; pointer now 0, source 0
    set_word(0, 16'h01AB);
    full_i  = 4'b0010;
    pndng_i = 4'b0001;
    tick();
    check("t3_pop", 32'(pop_o), 32'h1);
    pndng_i = 4'b0000;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t3_hold%0d", c), 32'(push_o), 32'h0);
      check($sformatf("t3_busy%0d", c), 32'(busy_o), 32'h1);
    end
    check("t3_dato_hold", 32'(dato_o), 32'h01AB);
    full_i = 4'b0000;
    tick();
    check("t3_push", 32'(push_o), 32'h2);
    check("t3_dato", 32'(dato_o), 32'h01AB);
    check("t3_idle", 32'(busy_o), 32'h0);

    // 4a) out-of-range dest 5 from device 1
    set_word(1, 16'h0577);
    pndng_i = 4'b0010;
    tick();
    check("t4a_gnt", 32'(gnt_id_o), 32'h1);
    pndng_i = 4'b0000;
    tick();
    tick();
    check("t4a_err",  32'(err_o),  32'h1);
    check("t4a_push", 32'(push_o), 32'h0);
    tick();
    check("t4a_err_off", 32'(err_o), 32'h0);

    // 4b) dest equal to source (device 2)
    set_word(2, 16'h0233);
    pndng_i = 4'b0100;
    tick();
    check("t4b_gnt", 32'(gnt_id_o), 32'h2);
    pndng_i = 4'b0000;
    tick();
    tick();
    check("t4b_err",  32'(err_o),  32'h1);
    check("t4b_push", 32'(push_o), 32'h0);
    tick();
    check("t4b_err_off", 32'(err_o), 32'h0);

    // 5) reset while holding in DELIVER
    set_word(3, 16'h0011);
    full_i  = 4'b0001;
    pndng_i = 4'b1000;
    tick();
    check("t5_gnt", 32'(gnt_id_o), 32'h3);
    pndng_i = 4'b0000;
    tick();
    tick();
    check("t5_busy", 32'(busy_o), 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("t5_rst");
    tick();
    rst     = 1'b0;
    full_i  = 4'b0000;
    pndng_i = 4'b1111;
    tick();
    check("t5_gnt0", 32'(gnt_id_o), 32'h0);
    check("t5_pop0", 32'(pop_o),    32'h1);
    pndng_i = 4'b0000;
    tick();
    tick();
    check("t5_push", 32'(push_o), 32'h2);

    // 6) device 2 sends to the all-ones ID; its own full flag is set
    set_word(2, 16'hFF5A);
    full_i  = 4'b0100;
    pndng_i = 4'b0100;
    tick();
    check("t6_gnt", 32'(gnt_id_o), 32'h2);
    pndng_i = 4'b0000;
    tick();
    tick();
`ifdef BUS_BCAST_EN
    check("t6_push", 32'(push_o), 32'hB);
    check("t6_err",  32'(err_o),  32'h0);
    check("t6_dato", 32'(dato_o), 32'hFF5A);
`else
    check("t6_push", 32'(push_o), 32'h0);
    check("t6_err",  32'(err_o),  32'h1);
`endif
    full_i = 4'b0000;
    tick();
    check("t6_done", 32'(busy_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
